lcd_pclk_gen: RTL and testbench

//  Parametrised LCD pixel-clock generator, successor to the fixed /1,/2,/4 selector.

---
 rtl/lcd_pclk_pkg.sv | 36 +++
 rtl/lcd_pclk_gen_if.sv | 44 ++++
 rtl/lcd_id_debounce.sv | 38 +++
 rtl/lcd_pclk_gen.sv | 140 ++++++++++++++
 tb/tb_lcd_pclk_gen.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pclk_pkg.sv
// Shared types and panel table for the LCD pixel-clock generator.
// Maps panel IDs to clk divisors; 0 means stop.
package lcd_pclk_pkg;

  localparam int DIV_W_DEF = 8;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_4384 = 16'h4384;
  localparam logic [15:0] ID_1018 = 16'h1018;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_DRAIN,
    ST_GAP
  } pclk_state_e;

  function automatic logic [DIV_W_DEF-1:0] id_to_div(
    input logic [15:0] id
  );
    logic [DIV_W_DEF-1:0] d;
    d = '0;
    unique case (1'b1)
      (id == ID_4342): d = DIV_W_DEF'(8);
      (id == ID_7084): d = DIV_W_DEF'(4);
      (id == ID_7016): d = DIV_W_DEF'(2);
      (id == ID_4384): d = DIV_W_DEF'(4);
      (id == ID_1018): d = DIV_W_DEF'(2);
      default:         d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lcd_pclk_gen_if.sv
// Pixel-clock generator bus: panel ID in, clock/strobes/status out.
// LCD_PCLK_OVERRIDE_EN adds the divisor override inputs.
interface lcd_pclk_gen_if
  import lcd_pclk_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
);

  logic [15:0]      lcd_id;
  logic             lcd_pclk;
  logic             pclk_rise;
  logic             pclk_fall;
  logic             pclk_locked;
  logic [DIV_W-1:0] div_cur;
`ifdef LCD_PCLK_OVERRIDE_EN
  logic [DIV_W-1:0] div_ovr;
  logic             div_ovr_vld;

  modport master (
    input  lcd_id, div_ovr, div_ovr_vld,
    output lcd_pclk, pclk_rise, pclk_fall,
    output pclk_locked, div_cur
  );

  modport slave (
    output lcd_id, div_ovr, div_ovr_vld,
    input  lcd_pclk, pclk_rise, pclk_fall,
    input  pclk_locked, div_cur
  );
`else
  modport master (
    input  lcd_id,
    output lcd_pclk, pclk_rise, pclk_fall,
    output pclk_locked, div_cur
  );

  modport slave (
    output lcd_id,
    input  lcd_pclk, pclk_rise, pclk_fall,
    input  pclk_locked, div_cur
  );
`endif

endinterface

// File: rtl/lcd_id_debounce.sv
// Accepts a word only after STABLE_CYC consecutive equal cycles.
// id_stable stays high while the input keeps matching.
module lcd_id_debounce #(
  parameter int W          = 16,
  parameter int STABLE_CYC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic         id_stable,
  output logic [W-1:0] id_acc
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [W-1:0]  samp;
  logic [CW-1:0] run;

  // count equal cycles; latch the word when the count completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp   <= '0;
      run    <= '0;
      id_acc <= '0;
    end else if (din != samp) begin
      samp <= din;
      run  <= CW'(1);
    end else if (run != CW'(STABLE_CYC)) begin
      run <= run + CW'(1);
      if (run == CW'(STABLE_CYC - 1)) begin
        id_acc <= din;
      end
    end
  end

  assign id_stable = (run == CW'(STABLE_CYC));

endmodule

// File: rtl/lcd_pclk_gen.sv
// LCD pixel-clock generator with glitch-free divisor switching.
// Optional macro LCD_PCLK_OVERRIDE_EN enables div_ovr/div_ovr_vld.
module lcd_pclk_gen
  import lcd_pclk_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int STABLE_CYC = 16,
  parameter int GAP_CYC    = 4
) (
  input logic            clk,
  input logic            rst_n,
  lcd_pclk_gen_if.master bus
);

  localparam int GW = $clog2(GAP_CYC + 1);

  logic             id_stable;
  logic [DIV_W-1:0] tgt_raw;
  logic [DIV_W-1:0] tgt;

`ifdef LCD_PCLK_OVERRIDE_EN
  localparam int DW = 16 + DIV_W + 1;

  logic [DW-1:0] din;
  logic [DW-1:0] acc;

  assign din = {bus.div_ovr_vld, bus.div_ovr, bus.lcd_id};
  assign tgt_raw = acc[DW-1] ? acc[DW-2:16]
                             : DIV_W'(id_to_div(acc[15:0]));
`else
  localparam int DW = 16;

  logic [DW-1:0] din;
  logic [DW-1:0] acc;

  assign din = bus.lcd_id;
  assign tgt_raw = DIV_W'(id_to_div(acc));
`endif

  lcd_id_debounce #(
    .W          (DW),
    .STABLE_CYC (STABLE_CYC)
  ) u_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .id_stable (id_stable),
    .id_acc    (acc)
  );

  assign tgt = (tgt_raw == DIV_W'(1)) ? DIV_W'(2) : tgt_raw;

  pclk_state_e      state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] div_cur, div_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             pclk, pclk_n;
  logic             rise, rise_n;
  logic             fall, fall_n;

  logic [DIV_W-1:0] cnt_inc;
  logic             hi;

  assign cnt_inc = (cnt == div_cur - DIV_W'(1)) ? '0
                                                 : cnt + DIV_W'(1);
  assign hi = (cnt < (div_cur >> 1));

  // state, phase counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_STOP;
      cnt     <= '0;
      div_cur <= '0;
      gcnt    <= '0;
      pclk    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_cur <= div_n;
      gcnt    <= gcnt_n;
      pclk    <= pclk_n;
      rise    <= rise_n;
      fall    <= fall_n;
    end
  end

  // next state; pclk follows the phase of the count being left
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_cur;
    gcnt_n  = gcnt;
    pclk_n  = 1'b0;
    unique case (state)
      ST_STOP: begin
        if (tgt != '0) begin
          state_n = ST_RUN;
          div_n   = tgt;
          cnt_n   = '0;
        end
      end
      ST_RUN: begin
        pclk_n = hi;
        cnt_n  = cnt_inc;
        if (tgt != div_cur) begin
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) begin
          state_n = ST_GAP;
          gcnt_n  = '0;
        end else begin
          pclk_n = hi;
          cnt_n  = cnt_inc;
        end
      end
      ST_GAP: begin
        if (gcnt < GW'(GAP_CYC - 1)) begin
          gcnt_n = gcnt + GW'(1);
        end else if (id_stable) begin
          cnt_n = '0;
          div_n = tgt;
          state_n = (tgt == '0) ? ST_STOP : ST_RUN;
        end
      end
    endcase
    rise_n = pclk_n & ~pclk;
    fall_n = ~pclk_n & pclk;
  end

  assign bus.lcd_pclk    = pclk;
  assign bus.pclk_rise   = rise;
  assign bus.pclk_fall   = fall;
  assign bus.pclk_locked = (state == ST_RUN);
  assign bus.div_cur     = div_cur;

endmodule

// File: tb/tb_lcd_pclk_gen.sv
// Directed bench for lcd_pclk_gen.
// Define LCD_PCLK_OVERRIDE_EN to also exercise the override path.
module tb_lcd_pclk_gen;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  lcd_pclk_gen_if #(.DIV_W(8)) bus ();

  lcd_pclk_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic observe(
    input  int n,
    output int min_hi, output int max_hi,
    output int min_lo, output int max_lo,
    output int rises, output int falls,
    output int serr
  );
    logic prev, cur;
    int   run;
    bit   started;
    prev = bus.lcd_pclk;
    run = 0; started = 0;
    min_hi = 1000; max_hi = 0;
    min_lo = 1000; max_lo = 0;
    rises = 0; falls = 0; serr = 0;
    repeat (n) begin
      @(negedge clk);
      cur = bus.lcd_pclk;
      if (bus.pclk_rise !== (cur & ~prev)) serr++;
      if (bus.pclk_fall !== (~cur & prev)) serr++;
      if (bus.pclk_rise === 1'b1) rises++;
      if (bus.pclk_fall === 1'b1) falls++;
      if (cur == prev) begin
        run++;
      end else begin
        if (started) begin
          if (prev) begin
            if (run < min_hi) min_hi = run;
            if (run > max_hi) max_hi = run;
          end else begin
            if (run < min_lo) min_lo = run;
            if (run > max_lo) max_lo = run;
          end
        end
        started = 1;
        run = 1;
      end
      prev = cur;
    end
  endtask

  task automatic wait_lock(
    input logic [7:0] d, input int budget, output bit ok
  );
    int w;
    w = 0;
    while (!(bus.pclk_locked === 1'b1 && bus.div_cur === d)
           && w < budget) begin
      @(negedge clk);
      w++;
    end
    ok = (bus.pclk_locked === 1'b1 && bus.div_cur === d);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.lcd_id = 16'h7084;
`ifdef LCD_PCLK_OVERRIDE_EN
    bus.div_ovr = '0;
    bus.div_ovr_vld = 1'b0;
`endif
    tick(3);
    total++;
    if (bus.lcd_pclk !== 1'b0)
      $display("FAIL rst_pclk got %b want 0", bus.lcd_pclk);
    else passed++;
    total++;
    if (bus.pclk_rise !== 1'b0 || bus.pclk_fall !== 1'b0)
      $display("FAIL rst_strobe got %b%b want 00",
               bus.pclk_rise, bus.pclk_fall);
    else passed++;
    total++;
    if (bus.pclk_locked !== 1'b0)
      $display("FAIL rst_locked got %b want 0", bus.pclk_locked);
    else passed++;
    total++;
    if (bus.div_cur !== 8'd0)
      $display("FAIL rst_div got %0d want 0", bus.div_cur);
    else passed++;
  endtask

  task automatic test_lock;
    int mnh, mxh, mnl, mxl, r, f, se;
    rst_n = 1'b1;
    tick(16);
    total++;
    if (bus.pclk_locked !== 1'b0)
      $display("FAIL lock_early got %b want 0", bus.pclk_locked);
    else passed++;
    tick(1);
    total++;
    if (bus.pclk_locked !== 1'b1 || bus.div_cur !== 8'd4)
      $display("FAIL lock_run got lk=%b div=%0d want lk=1 div=4",
               bus.pclk_locked, bus.div_cur);
    else passed++;
    total++;
    if (bus.lcd_pclk !== 1'b0)
      $display("FAIL lock_first got %b want 0", bus.lcd_pclk);
    else passed++;
    tick(1);
    total++;
    if (bus.lcd_pclk !== 1'b1 || bus.pclk_rise !== 1'b1)
      $display("FAIL lock_rise got p=%b r=%b want p=1 r=1",
               bus.lcd_pclk, bus.pclk_rise);
    else passed++;
    observe(40, mnh, mxh, mnl, mxl, r, f, se);
    total++;
    if (mnh !== 2 || mxh !== 2 || mnl !== 2 || mxl !== 2)
      $display("FAIL div4_shape got h=%0d..%0d l=%0d..%0d want 2..2",
               mnh, mxh, mnl, mxl);
    else passed++;
    total++;
    if (r !== 10 || f !== 10)
      $display("FAIL div4_edges got r=%0d f=%0d want 10", r, f);
    else passed++;
    total++;
    if (se !== 0)
      $display("FAIL div4_strobe got %0d errors want 0", se);
    else passed++;
  endtask

  task automatic test_switch;
    int mnh, mxh, mnl, mxl, r, f, se;
    bus.lcd_id = 16'h4342;
    observe(60, mnh, mxh, mnl, mxl, r, f, se);
    total++;
    if (mnh < 2 || mnl < 2)
      $display("FAIL sw_min got h=%0d l=%0d want >=2", mnh, mnl);
    else passed++;
    total++;
    if (mxl !== 7 || mxh !== 4)
      $display("FAIL sw_gap got lo=%0d hi=%0d want lo=7 hi=4",
               mxl, mxh);
    else passed++;
    total++;
    if (se !== 0)
      $display("FAIL sw_strobe got %0d errors want 0", se);
    else passed++;
    total++;
    if (bus.pclk_locked !== 1'b1 || bus.div_cur !== 8'd8)
      $display("FAIL sw_lock got lk=%b div=%0d want lk=1 div=8",
               bus.pclk_locked, bus.div_cur);
    else passed++;
    observe(48, mnh, mxh, mnl, mxl, r, f, se);
    total++;
    if (mnh !== 4 || mxh !== 4 || mnl !== 4 || mxl !== 4
        || r !== 6 || se !== 0)
      $display("FAIL div8_shape got h=%0d..%0d l=%0d..%0d r=%0d se=%0d want 4/4 r=6 se=0",
               mnh, mxh, mnl, mxl, r, se);
    else passed++;
  endtask

  task automatic test_toggle;
    int mnh, mxh, mnl, mxl, r, f, se;
    fork
      observe(80, mnh, mxh, mnl, mxl, r, f, se);
      begin
        repeat (8) begin
          bus.lcd_id = 16'h7016;
          tick(5);
          bus.lcd_id = 16'h1018;
          tick(5);
        end
      end
    join
    bus.lcd_id = 16'h4342;
    total++;
    if (bus.div_cur !== 8'd8 || bus.pclk_locked !== 1'b1)
      $display("FAIL tog_div got div=%0d lk=%b want div=8 lk=1",
               bus.div_cur, bus.pclk_locked);
    else passed++;
    total++;
    if (mnh !== 4 || mxh !== 4 || mnl !== 4 || mxl !== 4
        || r !== 10 || se !== 0)
      $display("FAIL tog_shape got h=%0d..%0d l=%0d..%0d r=%0d se=%0d want 4/4 r=10 se=0",
               mnh, mxh, mnl, mxl, r, se);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int w;
    w = 0;
    while (bus.pclk_rise !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (bus.pclk_rise !== 1'b1)
      $display("FAIL rm_rise got %b want 1", bus.pclk_rise);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.lcd_pclk !== 1'b0 || bus.pclk_locked !== 1'b0
        || bus.div_cur !== 8'd0)
      $display("FAIL rm_async got p=%b lk=%b div=%0d want 0 0 0",
               bus.lcd_pclk, bus.pclk_locked, bus.div_cur);
    else passed++;
    tick(2);
    rst_n = 1'b1;
    tick(16);
    total++;
    if (bus.pclk_locked !== 1'b0)
      $display("FAIL rm_early got %b want 0", bus.pclk_locked);
    else passed++;
    tick(1);
    total++;
    if (bus.pclk_locked !== 1'b1 || bus.div_cur !== 8'd8)
      $display("FAIL rm_relock got lk=%b div=%0d want lk=1 div=8",
               bus.pclk_locked, bus.div_cur);
    else passed++;
  endtask

  task automatic test_stop;
    int mnh, mxh, mnl, mxl, r, f, se, w;
    bus.lcd_id = 16'hFFFF;
    w = 0;
    while (!(bus.div_cur === 8'd0 && bus.pclk_locked === 1'b0)
           && w < 60) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (bus.div_cur !== 8'd0 || bus.pclk_locked !== 1'b0)
      $display("FAIL stop_state got div=%0d lk=%b want 0 0",
               bus.div_cur, bus.pclk_locked);
    else passed++;
    observe(20, mnh, mxh, mnl, mxl, r, f, se);
    total++;
    if (r !== 0 || f !== 0 || bus.lcd_pclk !== 1'b0 || mxh !== 0)
      $display("FAIL stop_quiet got r=%0d f=%0d p=%b hi=%0d want 0",
               r, f, bus.lcd_pclk, mxh);
    else passed++;
  endtask

`ifdef LCD_PCLK_OVERRIDE_EN
  task automatic test_override;
    int mnh, mxh, mnl, mxl, r, f, se;
    bit ok;
    bus.div_ovr = 8'd5;
    bus.div_ovr_vld = 1'b1;
    wait_lock(8'd5, 60, ok);
    total++;
    if (!ok)
      $display("FAIL ovr5_lock got div=%0d want 5", bus.div_cur);
    else passed++;
    observe(50, mnh, mxh, mnl, mxl, r, f, se);
    total++;
    if (mnh !== 2 || mxh !== 2 || mnl !== 3 || mxl !== 3
        || r !== 10 || se !== 0)
      $display("FAIL ovr5_shape got h=%0d..%0d l=%0d..%0d r=%0d se=%0d want 2H3L",
               mnh, mxh, mnl, mxl, r, se);
    else passed++;
    bus.div_ovr = 8'd1;
    wait_lock(8'd2, 80, ok);
    total++;
    if (!ok)
      $display("FAIL ovr1_clamp got div=%0d want 2", bus.div_cur);
    else passed++;
    observe(20, mnh, mxh, mnl, mxl, r, f, se);
    total++;
    if (mnh !== 1 || mxh !== 1 || mnl !== 1 || mxl !== 1
        || r !== 10 || se !== 0)
      $display("FAIL ovr1_shape got h=%0d..%0d l=%0d..%0d r=%0d se=%0d want 1H1L",
               mnh, mxh, mnl, mxl, r, se);
    else passed++;
  endtask
`endif

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_lock();
    test_switch();
    test_toggle();
    test_reset_mid();
    test_stop();
`ifdef LCD_PCLK_OVERRIDE_EN
    test_override();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
